// File: rtl/uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receiver.
// Contents: register offsets inside the 16-byte window, STATUS bit indices,
// bus responder and receiver FSM state types, and the minimum divisor.
package uart_rx_pkg;

   // Register offsets relative to BASE
   localparam logic [3:0] OFF_DATA   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_DIV    = 4'h8;

   // STATUS bit positions
   localparam int unsigned ST_NOT_EMPTY = 0;
   localparam int unsigned ST_FULL      = 1;
   localparam int unsigned ST_OVERRUN   = 2;
   localparam int unsigned ST_FRAME_ERR = 3;

   // Smallest divisor the receiver can run with (needs DIV/2 >= 2)
   localparam logic [15:0] MIN_DIV = 16'd4;

   typedef enum logic [1:0] {
      B_IDLE,
      B_ACK,
      B_WAIT
   } bus_state_t;

   typedef enum logic [2:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP,
      R_BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with an extra wrap bit on each pointer to tell
// full from empty. A pop is applied before a push in the same cycle, so a
// push into a full FIFO that is being popped is accepted.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   push, wdata write request and byte (dropped when full and not popping)
//   pop, rdata  read request and head-of-queue byte (ignored when empty)
//   full, empty occupancy flags from the pointer registers
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_q, rd_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign rdata = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PTR_ONE;
         if (do_pop)  rd_q <= rd_q + PTR_ONE;
      end
   end

   // Storage needs no reset; the pointers define which entries are valid
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_rx_periph.sv
// Memory-mapped 8N1 UART receiver on the request/acknowledge peripheral bus.
// Decodes a 16-byte window at BASE: DATA (pop), STATUS (sticky flags,
// write-1-to-clear) and DIV (clocks per bit).
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   address, rw_req, rw, write_data, size   bus request (size ignored)
//   read_data, rec   read result and one-cycle acknowledge
//   rin              serial input, idle high
//   rx_irq           high while the receive FIFO holds data
module uart_rx_periph
   import uart_rx_pkg::*;
#(
   parameter logic [31:0] BASE        = 32'h8000_0020,
   parameter int unsigned DEFAULT_DIV = 434,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        rw_req,
   input  logic        rw,
   input  logic [31:0] write_data,
   input  logic [1:0]  size,
   output logic [31:0] read_data,
   output logic        rec,
   input  logic        rin,
   output logic        rx_irq
);

   localparam logic [15:0] DIV_RESET = DEFAULT_DIV[15:0];

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   logic [31:0] offset_full;
   logic [3:0]  offset;
   logic        hit;

   assign offset_full = address - BASE;
   assign hit         = (offset_full < 32'd16);
   assign offset      = offset_full[3:0];

   logic unused_bits;
   assign unused_bits = ^{size, write_data[31:16]};

   // ---------------------------------------------------------------------
   // Registers and FIFO
   // ---------------------------------------------------------------------
   logic [15:0] div_q;
   logic        overrun_q, frame_err_q;
   logic        fifo_full, fifo_empty, fifo_pop;
   logic [7:0]  fifo_rdata;
   logic [3:0]  status;

   logic        div_we, clr_ovr, clr_ferr, ferr_set, ovr_set;
   logic        push_q, push_d;
   logic [7:0]  shreg_q, shreg_d;

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_q),
      .wdata (shreg_q),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      status               = '0;
      status[ST_NOT_EMPTY] = !fifo_empty;
      status[ST_FULL]      = fifo_full;
      status[ST_OVERRUN]   = overrun_q;
      status[ST_FRAME_ERR] = frame_err_q;
   end

   assign rx_irq = !fifo_empty;

   // A push lost to a full FIFO; a same-cycle pop makes room first
   assign ovr_set = push_q && fifo_full && !fifo_pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q       <= DIV_RESET;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (div_we) begin
            div_q <= (write_data[15:0] < MIN_DIV) ? MIN_DIV : write_data[15:0];
         end
         // A new event outranks a clear landing on the same edge
         if (ovr_set)       overrun_q <= 1'b1;
         else if (clr_ovr)  overrun_q <= 1'b0;
         if (ferr_set)      frame_err_q <= 1'b1;
         else if (clr_ferr) frame_err_q <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Bus responder FSM
   // ---------------------------------------------------------------------
   bus_state_t bus_q, bus_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) bus_q <= B_IDLE;
      else       bus_q <= bus_d;
   end

   always_comb begin
      bus_d     = bus_q;
      rec       = 1'b0;
      read_data = '0;
      fifo_pop  = 1'b0;
      div_we    = 1'b0;
      clr_ovr   = 1'b0;
      clr_ferr  = 1'b0;
      unique case (bus_q)
         B_IDLE: begin
            if (rw_req && hit) bus_d = B_ACK;
         end
         B_ACK: begin
            rec   = 1'b1;
            bus_d = B_WAIT;
            if (rw) begin
               case (offset)
                  OFF_STATUS: begin
                     clr_ovr  = write_data[ST_OVERRUN];
                     clr_ferr = write_data[ST_FRAME_ERR];
                  end
                  OFF_DIV: div_we = 1'b1;
                  default: ;
               endcase
            end else begin
               case (offset)
                  OFF_DATA: begin
                     if (!fifo_empty) begin
                        read_data = {24'b0, fifo_rdata};
                        fifo_pop  = 1'b1;
                     end
                  end
                  OFF_STATUS: read_data = {28'b0, status};
                  OFF_DIV:    read_data = {16'b0, div_q};
                  default: ;
               endcase
            end
         end
         B_WAIT: begin
            // Held request gets no second ack
            if (!rw_req) bus_d = B_IDLE;
         end
         default: bus_d = B_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Input synchroniser and falling-edge detect
   // ---------------------------------------------------------------------
   logic rin_meta, rin_sync, rin_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rin_meta <= 1'b1;
         rin_sync <= 1'b1;
         rin_prev <= 1'b1;
      end else begin
         rin_meta <= rin;
         rin_sync <= rin_meta;
         rin_prev <= rin_sync;
      end
   end

   // ---------------------------------------------------------------------
   // Receiver FSM and baud counter
   // ---------------------------------------------------------------------
   rx_state_t   rx_q, rx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] div_frame_q, div_frame_d;
   logic [2:0]  bits_q, bits_d;
   logic        tick;

   assign tick = (cnt_q == 16'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_q        <= R_IDLE;
         cnt_q       <= '0;
         div_frame_q <= DIV_RESET;
         bits_q      <= '0;
         shreg_q     <= '0;
         push_q      <= 1'b0;
      end else begin
         rx_q        <= rx_d;
         cnt_q       <= cnt_d;
         div_frame_q <= div_frame_d;
         bits_q      <= bits_d;
         shreg_q     <= shreg_d;
         push_q      <= push_d;
      end
   end

   always_comb begin
      rx_d        = rx_q;
      cnt_d       = cnt_q;
      div_frame_d = div_frame_q;
      bits_d      = bits_q;
      shreg_d     = shreg_q;
      push_d      = 1'b0;
      ferr_set    = 1'b0;

      // Timed states count down; each case reloads on its own tick
      if (rx_q inside {R_START, R_DATA, R_STOP} && !tick) begin
         cnt_d = cnt_q - 16'd1;
      end

      unique case (rx_q)
         R_IDLE: begin
            if (rin_prev && !rin_sync) begin
               rx_d        = R_START;
               cnt_d       = div_q >> 1;
               div_frame_d = div_q; // divisor frozen for the whole frame
            end
         end
         R_START: begin
            if (tick) begin
               if (!rin_sync) begin
                  rx_d   = R_DATA;
                  cnt_d  = div_frame_q - 16'd1;
                  bits_d = '0;
               end else begin
                  rx_d = R_IDLE;
               end
            end
         end
         R_DATA: begin
            if (tick) begin
               shreg_d = {rin_sync, shreg_q[7:1]};
               bits_d  = bits_q + 3'd1;
               cnt_d   = div_frame_q - 16'd1;
               if (bits_q == 3'd7) rx_d = R_STOP;
            end
         end
         R_STOP: begin
            if (tick) begin
               if (rin_sync) begin
                  push_d = 1'b1;
                  rx_d   = R_IDLE;
               end else begin
                  ferr_set = 1'b1;
                  rx_d     = R_BREAK;
               end
            end
         end
         R_BREAK: begin
            if (rin_sync) rx_d = R_IDLE;
         end
         default: rx_d = R_IDLE;
      endcase
   end

endmodule
